// File: rtl/adc_trg_pkg.sv
// adc_trg_pkg: shared types and constants for the ADC trigger generator.
//   chan_state_e : per-channel FSM state (IDLE, DELAY, RUN, DONE)
//   MODE_TOGGLE  : square wave, high/low time = half_q
//   MODE_PULSE   : one-cycle pulse every half_q cycles
package adc_trg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } chan_state_e;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/adc_trg_chan.sv
// adc_trg_chan: one trigger channel (FSM + period/phase/burst counters).
// All state advances on the falling edge of fpga_clk.
// Optional feature macro: ADC_TRG_BURST_EN (burst counting, DONE state, done).
// Ports:
//   fpga_clk, rst        clock (negedge) and async active-high reset
//   en                   run enable level; low returns the channel to IDLE
//   mode_in              mode, latched when leaving IDLE
//   phase_in             start delay in cycles, latched when leaving IDLE
//   burst_in             rising edges per burst (0 = infinite), latched in IDLE
//   half                 shared half-period, compared live every edge
//   trg_out              trigger output
//   trg_stb              one-cycle strobe on every 0->1 of trg_out
//   done                 burst complete, held until en drops
//   dbg_state            current FSM state
// Handshake: none; en is a level, every output is a registered level/strobe.
module adc_trg_chan
    import adc_trg_pkg::*;
#(
    parameter int CNT_W   = 20,
    parameter int BURST_W = 16
) (
    input  logic               fpga_clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode_in,
    input  logic [CNT_W-1:0]   phase_in,
    input  logic [BURST_W-1:0] burst_in,
    input  logic [CNT_W-1:0]   half,
    output logic               trg_out,
    output logic               trg_stb,
    output logic               done,
    output logic [1:0]         dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             mode_q, mode_d;
    logic             out_q, out_d;
    logic             stb_q, stb_d;
    logic             fire;

    // Compare is >= so that a half-period shrunk below cnt fires next edge.
    assign fire = (cnt_q >= half);

`ifdef ADC_TRG_BURST_EN
    localparam logic [BURST_W-1:0] BURST_ONE = 1;

    logic [BURST_W-1:0] bcnt_q, bcnt_d;
    logic [BURST_W-1:0] blen_q, blen_d;
    logic               done_q, done_d;
    logic               burst_hit;

    // Last rising edge of a finite burst has been produced.
    assign burst_hit = (blen_q != '0) && (bcnt_q == blen_q);
    assign done      = done_q;
`else
    logic unused_burst;

    assign unused_burst = ^burst_in;
    assign done         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        mode_d  = mode_q;
        out_d   = out_q;
        stb_d   = 1'b0;
`ifdef ADC_TRG_BURST_EN
        bcnt_d  = bcnt_q;
        blen_d  = blen_q;
        done_d  = done_q;
`endif
        if (!en) begin
            // Abort from any state; a partial pulse is not completed.
            state_d = IDLE;
            cnt_d   = '0;
            dcnt_d  = '0;
            out_d   = 1'b0;
`ifdef ADC_TRG_BURST_EN
            bcnt_d  = '0;
            done_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    mode_d = mode_in;
`ifdef ADC_TRG_BURST_EN
                    blen_d = burst_in;
`endif
                    if (phase_in == '0) begin
                        state_d = RUN;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = DELAY;
                        dcnt_d  = phase_in;
                    end
                end
                DELAY: begin
                    if (dcnt_q == CNT_ONE) begin
                        state_d = RUN;
                        cnt_d   = CNT_ONE;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q - CNT_ONE;
                    end
                end
                RUN: begin
`ifdef ADC_TRG_BURST_EN
                    // Pulse mode: the final pulse ends on the edge after it rose.
                    if (mode_q == MODE_PULSE && out_q && burst_hit) begin
                        state_d = DONE;
                        out_d   = 1'b0;
                        done_d  = 1'b1;
                    end else
`endif
                    if (fire) begin
                        cnt_d = CNT_ONE;
                        if (mode_q == MODE_TOGGLE && out_q) begin
                            out_d = 1'b0;
`ifdef ADC_TRG_BURST_EN
                            if (burst_hit) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
`endif
                        end else begin
                            // With half = 1 in pulse mode out stays high and
                            // only the first rise is strobed.
                            out_d = 1'b1;
                            if (!out_q) begin
                                stb_d  = 1'b1;
`ifdef ADC_TRG_BURST_EN
                                bcnt_d = bcnt_q + BURST_ONE;
`endif
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (mode_q == MODE_PULSE) begin
                            out_d = 1'b0;
                        end
                    end
                end
                DONE: begin
                    out_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(negedge fpga_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            mode_q  <= MODE_TOGGLE;
            out_q   <= 1'b0;
            stb_q   <= 1'b0;
`ifdef ADC_TRG_BURST_EN
            bcnt_q  <= '0;
            blen_q  <= '0;
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            stb_q   <= stb_d;
`ifdef ADC_TRG_BURST_EN
            bcnt_q  <= bcnt_d;
            blen_q  <= blen_d;
            done_q  <= done_d;
`endif
        end
    end

    assign trg_out   = out_q;
    assign trg_stb   = stb_q;
    assign dbg_state = state_q;

endmodule

// File: rtl/adc_trg_gen.sv
// adc_trg_gen: multi-channel run-time programmable ADC trigger generator.
// Holds the shared half-period register and slices the per-channel buses.
// Optional feature macro: ADC_TRG_BURST_EN (finite bursts and done output).
// Ports:
//   fpga_clk     system clock, logic runs on the falling edge
//   rst          asynchronous active-high reset
//   adc_en       per-channel run enable (level)
//   mode         per-channel mode (0 toggle, 1 pulse)
//   cfg_load     one-cycle strobe latching half_in (0 is ignored)
//   half_in      new half-period
//   phase_off    per-channel start delay, channel c at [c*CNT_W +: CNT_W]
//   burst_len    rising edges per burst, 0 = infinite
//   adc_trg_out  trigger outputs
//   trg_stb      one-cycle strobe per rising trigger
//   done         per-channel burst complete
module adc_trg_gen
    import adc_trg_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 20,
    parameter int DEF_HALF = 50000,
    parameter int BURST_W  = 16
) (
    input  logic                  fpga_clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       adc_en,
    input  logic [N_CH-1:0]       mode,
    input  logic                  cfg_load,
    input  logic [CNT_W-1:0]      half_in,
    input  logic [N_CH*CNT_W-1:0] phase_off,
    input  logic [BURST_W-1:0]    burst_len,
    output logic [N_CH-1:0]       adc_trg_out,
    output logic [N_CH-1:0]       trg_stb,
    output logic [N_CH-1:0]       done
);

    logic [CNT_W-1:0] half_q, half_d;
    logic [1:0]       chan_state_unused [N_CH];

    always_comb begin
        half_d = half_q;
        if (cfg_load && (half_in != '0)) begin
            half_d = half_in;
        end
    end

    always_ff @(negedge fpga_clk or posedge rst) begin
        if (rst) begin
            half_q <= CNT_W'(DEF_HALF);
        end else begin
            half_q <= half_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        adc_trg_chan #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_chan (
            .fpga_clk  (fpga_clk),
            .rst       (rst),
            .en        (adc_en[c]),
            .mode_in   (mode[c]),
            .phase_in  (phase_off[c*CNT_W +: CNT_W]),
            .burst_in  (burst_len),
            .half      (half_q),
            .trg_out   (adc_trg_out[c]),
            .trg_stb   (trg_stb[c]),
            .done      (done[c]),
            .dbg_state (chan_state_unused[c])
        );
    end

endmodule
